// File: rtl/pwm_capture.sv
// pwm_capture: measures period and active time of an asynchronous PWM input.
// The input is synchronised, optionally inverted, and edge-detected. A small
// FSM times rising-to-rising (period) and rising-to-falling (duty) intervals.
// Optional feature: define PWM_CAPTURE_TIMEOUT_EN to compile in the no-edge
// timeout. Without it, timeout and stuck_level are tied low.
module pwm_capture #(
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pwm_in,
  input  logic                     enable,
  input  logic                     polarity,
  input  logic [COUNTER_WIDTH-1:0] timeout_cycles,
  output logic [COUNTER_WIDTH-1:0] period,
  output logic [COUNTER_WIDTH-1:0] duty,
  output logic                     valid,
  output logic                     overflow,
  output logic                     timeout,
  output logic                     stuck_level
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StActive   = 2'd1;
  localparam logic [1:0] StInactive = 2'd2;

  localparam logic [COUNTER_WIDTH-1:0] CntMax = {COUNTER_WIDTH{1'b1}};
  localparam logic [COUNTER_WIDTH-1:0] CntOne = COUNTER_WIDTH'(1);

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v);
    return (v == CntMax) ? v : v + CntOne;
  endfunction

  logic [SYNC_STAGES-1:0]   sync_q;
  logic [SYNC_STAGES:0]     prime_q;
  logic                     prev_q;
  logic                     level;
  logic                     primed;
  logic                     rise;
  logic                     fall;
  logic                     to_fire;

  logic [1:0]               state_q, state_d;
  logic [COUNTER_WIDTH-1:0] run_q, run_d;
  logic [COUNTER_WIDTH-1:0] act_q, act_d;
  logic                     sat_q, sat_d;
  logic [COUNTER_WIDTH-1:0] period_q, period_d;
  logic [COUNTER_WIDTH-1:0] duty_q, duty_d;
  logic                     valid_q, valid_d;
  logic                     ovf_q, ovf_d;
  logic                     timeout_q, timeout_d;
  logic                     stuck_q, stuck_d;

  // Input synchroniser plus a delayed copy of the post-polarity level.
  // prime_q masks edges until the chain holds real samples after reset, so the
  // zeroed flops filling up with a high input are not mistaken for an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      prime_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
      prev_q  <= level;
    end
  end

  assign level  = sync_q[SYNC_STAGES-1] ^ polarity;
  assign primed = prime_q[SYNC_STAGES];
  assign rise   = primed & level & ~prev_q;
  assign fall   = primed & ~level & prev_q;

`ifdef PWM_CAPTURE_TIMEOUT_EN
  logic [COUNTER_WIDTH-1:0] noedge_q, noedge_d;

  assign to_fire = enable && (timeout_cycles != '0) && !(rise || fall) &&
                   (noedge_q == timeout_cycles - CntOne);

  // No-edge counter: restarts on any detected edge, on timeout, or while disabled.
  always_comb begin
    noedge_d = sat_inc(noedge_q);
    if (!enable || rise || fall || to_fire) begin
      noedge_d = '0;
    end
  end

  // No-edge counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      noedge_q <= '0;
    end else begin
      noedge_q <= noedge_d;
    end
  end
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^timeout_cycles;
  assign to_fire = 1'b0;
`endif

  // Measurement FSM and output next-state.
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    act_d     = act_q;
    sat_d     = sat_q;
    period_d  = period_q;
    duty_d    = duty_q;
    valid_d   = 1'b0;
    ovf_d     = 1'b0;
    timeout_d = 1'b0;
    stuck_d   = stuck_q;

    if (!enable) begin
      state_d = StIdle;
      run_d   = '0;
      act_d   = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (rise) begin
            state_d = StActive;
            run_d   = CntOne;
            act_d   = CntOne;
            sat_d   = 1'b0;
          end
        end
        StActive: begin
          run_d = sat_inc(run_q);
          if (run_q == CntMax) sat_d = 1'b1;
          if (fall) begin
            // Duty freezes on the falling-detect cycle itself.
            state_d = StInactive;
          end else begin
            act_d = sat_inc(act_q);
            if (act_q == CntMax) sat_d = 1'b1;
          end
        end
        StInactive: begin
          if (rise) begin
            period_d = run_q;
            duty_d   = act_q;
            valid_d  = 1'b1;
            ovf_d    = sat_q;
            run_d    = CntOne;
            act_d    = CntOne;
            sat_d    = 1'b0;
            state_d  = StActive;
          end else begin
            run_d = sat_inc(run_q);
            if (run_q == CntMax) sat_d = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          run_d   = '0;
          act_d   = '0;
          sat_d   = 1'b0;
        end
      endcase

      if (to_fire) begin
        timeout_d = 1'b1;
        stuck_d   = level;
        period_d  = '0;
        duty_d    = level ? CntMax : '0;
        state_d   = StIdle;
        run_d     = '0;
        act_d     = '0;
        sat_d     = 1'b0;
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      run_q     <= '0;
      act_q     <= '0;
      sat_q     <= 1'b0;
      period_q  <= '0;
      duty_q    <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      timeout_q <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      act_q     <= act_d;
      sat_q     <= sat_d;
      period_q  <= period_d;
      duty_q    <= duty_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      timeout_q <= timeout_d;
      stuck_q   <= stuck_d;
    end
  end

  assign period      = period_q;
  assign duty        = duty_q;
  assign valid       = valid_q;
  assign overflow    = ovf_q;
  assign timeout     = timeout_q;
  assign stuck_level = stuck_q;

endmodule
